wam_game_engine: RTL
====================

Name: wam_game_engine

Overview:
- Parametrised whack-a-mole game engine: the successor to the fixed 9-LED, fixed-mode game top.
- Owns the play FSM, random mole selection, light-on/gap timing, hit/miss scoring and all four game modes.
- Generalised over mole count, flick totals and timing.
- Sits between the keypad controller (hit_valid/hit_idx) and the LED outputs; switch decoding stays in the board top.

Parameters:
- NUM_MOLES, 9, number of lights/keys (2..16).
- IDX_W, 4, width of mole index; must satisfy 2^IDX_W < 2*NUM_MOLES.
- SCORE_W, 7, width of score/miss counters (saturating).
- NORMAL_FLICKS, 25, flicks per game when extended=0.
- EXTENDED_FLICKS, 50, flicks per game when extended=1.
- LEVEL_HITS, 8, hits per level advance in continuity mode.
- GAME_CYCLES, 1_500_000_000, total game length in timed mode (32-bit).
- TIMED_TARGET, 20, score needed to win timed mode.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle pulse; starts, or restarts, a game.
- mode  in  2  0 normal, 1 timed, 2 deathmatch, 3 continuity; sampled on start.
- extended  in  1  selects EXTENDED_FLICKS; sampled on start.
- time_on  in  28  light-on duration in cycles minus 1; sampled on start.
- time_between  in  28  gap duration in cycles minus 1; sampled on start.
- seed_load  in  1  loads seed into the LFSR (only while IDLE or DONE).
- seed  in  16  LFSR seed; the value 0 is replaced by 16'hACE1.
- hit_valid  in  1  one-cycle key press strobe.
- hit_idx  in  IDX_W  index of the pressed key.
- lights  out  NUM_MOLES  one-hot active mole, all zero otherwise.
- active_idx  out  IDX_W  index of the lit mole (valid while lights!=0).
- score  out  SCORE_W  hits this game.
- misses  out  SCORE_W  timeouts plus wrong keys this game.
- level  out  2  current level (continuity mode; 0 otherwise).
- playing  out  1  high in GAP or LIT.
- game_over  out  1  high in DONE.
- won  out  1  result, valid while game_over.

Behaviour:
- Reset: state IDLE; all outputs 0; LFSR = 16'hACE1; all counters 0.
- FSM states: IDLE, GAP, LIT, DONE.
  - IDLE/DONE, start: clear score, misses, flicks, level and game timer; latch inputs; load the timer with time_between>>level; go to GAP.
  - GAP: timer counts down; at 0, pick a mole, load the timer with time_on>>level, go to LIT (lights on the next cycle).
  - LIT, hit_valid and hit_idx==active_idx: score+1, flicks+1, lights off, go to GAP (or DONE if the flick quota is reached).
  - LIT, hit_valid and hit_idx!=active_idx: misses+1; the light stays on and the timer keeps running. In deathmatch, go straight to DONE.
  - LIT, timer reaches 0 with no hit: misses+1, flicks+1, then GAP or DONE as above. In deathmatch, go to DONE.
  - A correct hit on the same cycle as timer expiry counts as a hit.
  - start while in GAP or LIT: full restart, identical to start from IDLE. No score or miss change for the aborted flick.
- Effective time = base >> level. The timer counts from N down to 0, so a phase lasts N+1 cycles; N=0 gives 1 cycle.
- Mole pick:
  - r = lfsr[IDX_W-1:0]; if r>=NUM_MOLES then r -= NUM_MOLES.
  - If r equals the previous mole, r = (r+1) wrapping at NUM_MOLES.
  - The LFSR is a 16-bit Galois register with taps 16'hB400 and advances every cycle.
- Flick quota: NORMAL_FLICKS or EXTENDED_FLICKS. Timed mode has no quota.
- Timed mode: a 32-bit game timer counts every cycle from start. At GAME_CYCLES-1 it forces DONE from any play state; the in-flight flick counts neither hit nor miss.
- Continuity mode: level increments (saturating at 3) when score reaches LEVEL_HITS*(level+1). The new level applies from the next timer load.
- hit_valid in IDLE, GAP or DONE is ignored.
- score and misses saturate at all ones.
- won, evaluated on entry to DONE:
  - normal and continuity: score > misses;
  - timed: score >= TIMED_TARGET;
  - deathmatch: misses==0.
- DONE holds lights=0 and outputs stable until start or reset.

Decomposition:
- wam_pkg holds the mode encodings (MODE_NORMAL..MODE_CONTINUITY), the state enum, LFSR_TAPS, and the LFSR_DEFAULT seed.
- Sub-module wam_lfsr contains the 16-bit Galois LFSR with seed load and zero-seed substitution. The FSM, timers and scoring stay in wam_game_engine.

Test Plan:
- Normal timing. Reset; seed 16'h0001; mode 0, time_between=3, time_on=5; start. Required:
  - lights rise exactly 5 cycles after start;
  - with no input they stay on 6 cycles, then misses=1;
  - after 25 flicks: game_over=1, won=0, score=0.
- Correct hit. Mode 0; hit_valid with hit_idx=active_idx on the 2nd LIT cycle. Required: score=1, lights=0 on the next cycle, next mole != previous mole.
- Deathmatch. Mode 2; wrong key while LIT. Required: misses=1, game_over=1, won=0 on the next cycle. Repeat with 50 correct hits (extended=1): required won=1.
- Timed mode. Mode 1; GAME_CYCLES=200; hit every mole. Required: DONE at cycle 200 regardless of phase, no extra miss, won = (score>=TIMED_TARGET).
- Continuity mode. Mode 3, LEVEL_HITS=2, time_on=15. Required:
  - after 2 hits, level=1 and LIT lasts 8 cycles;
  - after 6 hits, level=3 and LIT lasts 2 cycles;
  - level stays at 3 afterwards.
- Restart and reset. Required:
  - start mid-LIT: score=misses=0, lights=0, GAP restarts;
  - reset asserted mid-GAP: all outputs 0 asynchronously;
  - hit equal to the expiry cycle counts as a hit.

Source files
------------

// File: rtl/wam_pkg.sv
// Shared encodings and constants for the whack-a-mole game engine.
package wam_pkg;

  localparam logic [1:0] MODE_NORMAL     = 2'd0;
  localparam logic [1:0] MODE_TIMED      = 2'd1;
  localparam logic [1:0] MODE_DEATHMATCH = 2'd2;
  localparam logic [1:0] MODE_CONTINUITY = 2'd3;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  // Phase timers hold the 28-bit light-on / gap durations.
  localparam int unsigned TIMER_W = 28;
  // Wide enough for any realistic flick quota.
  localparam int unsigned FLICK_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StGap,
    StLit,
    StDone
  } state_e;

  // Result of a finished game, judged on the counters as they enter DONE.
  function automatic logic game_won(input logic [1:0]  mode,
                                    input int unsigned score,
                                    input int unsigned misses,
                                    input int unsigned target);
    logic w;
    case (mode)
      MODE_TIMED:      w = (score >= target);
      MODE_DEATHMATCH: w = (misses == 0);
      default:         w = (score > misses);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wam_lfsr.sv
// 16-bit Galois LFSR that advances every cycle; a zero seed is replaced by the default.
module wam_lfsr
  import wam_pkg::*;
#(
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [15:0]      seed_i,
  output logic [OUT_W-1:0] rnd_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Next state: reseed on load, otherwise one Galois shift
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
    if (load_i) begin
      lfsr_d = (seed_i == 16'h0000) ? LFSR_DEFAULT : seed_i;
    end
  end

  // LFSR state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_DEFAULT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/wam_game_engine.sv
// Whack-a-mole game engine: play FSM, mole selection, phase timing, scoring and game modes.
module wam_game_engine
  import wam_pkg::*;
#(
  parameter int unsigned NUM_MOLES       = 9,
  parameter int unsigned IDX_W           = 4,
  parameter int unsigned SCORE_W         = 7,
  parameter int unsigned NORMAL_FLICKS   = 25,
  parameter int unsigned EXTENDED_FLICKS = 50,
  parameter int unsigned LEVEL_HITS      = 8,
  parameter int unsigned GAME_CYCLES     = 32'd1_500_000_000,
  parameter int unsigned TIMED_TARGET    = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 extended,
  input  logic [TIMER_W-1:0]   time_on,
  input  logic [TIMER_W-1:0]   time_between,
  input  logic                 seed_load,
  input  logic [15:0]          seed,
  input  logic                 hit_valid,
  input  logic [IDX_W-1:0]     hit_idx,
  output logic [NUM_MOLES-1:0] lights,
  output logic [IDX_W-1:0]     active_idx,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [1:0]           level,
  output logic                 playing,
  output logic                 game_over,
  output logic                 won
);

  localparam logic [IDX_W:0]   MolesW     = (IDX_W + 1)'(NUM_MOLES);
  localparam logic [31:0]      GameLast   = 32'(GAME_CYCLES - 1);
  localparam logic [FLICK_W-1:0] QuotaNorm = FLICK_W'(NORMAL_FLICKS);
  localparam logic [FLICK_W-1:0] QuotaExt  = FLICK_W'(EXTENDED_FLICKS);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]     mole_q, mole_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   misses_q, misses_d;
  logic [FLICK_W-1:0]   flicks_q, flicks_d;
  logic [1:0]           level_q, level_d;
  logic [31:0]          gtimer_q, gtimer_d;
  logic                 won_q, won_d;
  logic [1:0]           mode_q, mode_d;
  logic                 ext_q, ext_d;
  logic [TIMER_W-1:0]   ton_q, ton_d;
  logic [TIMER_W-1:0]   tgap_q, tgap_d;

  logic [IDX_W-1:0]     rnd;
  logic [IDX_W-1:0]     pick;
  logic [IDX_W:0]       pick_raw;
  logic                 in_play;
  logic                 lfsr_load;

  logic                 hit_ok, hit_bad, expire, flick_end, go_done, timed_end;
  logic [1:0]           miss_inc;
  logic [SCORE_W:0]     miss_sum;
  logic [31:0]          lvl_target;
  logic [FLICK_W-1:0]   quota;

  assign in_play   = (state_q == StGap) || (state_q == StLit);
  // Reseeding mid-game would make the mole sequence depend on switch timing.
  assign lfsr_load = seed_load && ((state_q == StIdle) || (state_q == StDone));

  wam_lfsr #(
    .OUT_W (IDX_W)
  ) u_lfsr (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (lfsr_load),
    .seed_i (seed),
    .rnd_o  (rnd)
  );

  // Mole pick: fold the random index into range, then step off the previous mole
  always_comb begin
    pick_raw = {1'b0, rnd};
    if (pick_raw >= MolesW) begin
      pick_raw = pick_raw - MolesW;
    end
    if (pick_raw[IDX_W-1:0] == mole_q) begin
      pick_raw = pick_raw + (IDX_W + 1)'(1);
      if (pick_raw == MolesW) begin
        pick_raw = '0;
      end
    end
    pick = pick_raw[IDX_W-1:0];
  end

  // Next-state logic for the play FSM, timers and scoring
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    mole_d     = mole_q;
    score_d    = score_q;
    misses_d   = misses_q;
    flicks_d   = flicks_q;
    level_d    = level_q;
    gtimer_d   = gtimer_q;
    won_d      = won_q;
    mode_d     = mode_q;
    ext_d      = ext_q;
    ton_d      = ton_q;
    tgap_d     = tgap_q;
    hit_ok     = 1'b0;
    hit_bad    = 1'b0;
    expire     = 1'b0;
    flick_end  = 1'b0;
    go_done    = 1'b0;
    miss_inc   = 2'd0;
    miss_sum   = '0;
    lvl_target = '0;
    quota      = ext_q ? QuotaExt : QuotaNorm;
    timed_end  = (mode_q == MODE_TIMED) && (gtimer_q == GameLast);

    if (in_play) begin
      gtimer_d = gtimer_q + 32'd1;
    end

    if (start) begin
      score_d  = '0;
      misses_d = '0;
      flicks_d = '0;
      level_d  = 2'd0;
      gtimer_d = '0;
      won_d    = 1'b0;
      mode_d   = mode;
      ext_d    = extended;
      ton_d    = time_on;
      tgap_d   = time_between;
      timer_d  = time_between;
      state_d  = StGap;
    end else if (in_play && timed_end) begin
      // The in-flight flick is abandoned without scoring.
      go_done = 1'b1;
    end else begin
      unique case (state_q)
        StGap: begin
          if (timer_q == '0) begin
            mole_d  = pick;
            timer_d = ton_q >> level_q;
            state_d = StLit;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        StLit: begin
          hit_ok  = hit_valid && (hit_idx == mole_q);
          hit_bad = hit_valid && !hit_ok;
          expire  = (timer_q == '0);
          if (hit_ok) begin
            // A correct hit wins even on the expiry cycle.
            score_d    = (&score_q) ? score_q : score_q + SCORE_W'(1);
            flick_end  = 1'b1;
            lvl_target = LEVEL_HITS * (32'(level_q) + 32'd1);
            if ((mode_q == MODE_CONTINUITY) && (level_q != 2'd3) &&
                (32'(score_d) >= lvl_target)) begin
              level_d = level_q + 2'd1;
            end
          end else begin
            miss_inc  = {1'b0, hit_bad} + {1'b0, expire};
            miss_sum  = {1'b0, misses_q} + (SCORE_W + 1)'(miss_inc);
            misses_d  = miss_sum[SCORE_W] ? '1 : miss_sum[SCORE_W-1:0];
            flick_end = expire;
            if ((mode_q == MODE_DEATHMATCH) && (hit_bad || expire)) begin
              go_done = 1'b1;
            end
            if (!expire) begin
              timer_d = timer_q - TIMER_W'(1);
            end
          end
          if (flick_end) begin
            flicks_d = flicks_q + FLICK_W'(1);
            if ((mode_q != MODE_TIMED) && (flicks_d == quota)) begin
              go_done = 1'b1;
            end else begin
              // The old level is used here; a level change shows from the next load.
              timer_d = tgap_q >> level_q;
              state_d = StGap;
            end
          end
        end
        default: ;
      endcase
    end

    if (go_done) begin
      state_d = StDone;
      won_d   = game_won(mode_q, 32'(score_d), 32'(misses_d), TIMED_TARGET);
    end
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      mole_q   <= '0;
      score_q  <= '0;
      misses_q <= '0;
      flicks_q <= '0;
      level_q  <= 2'd0;
      gtimer_q <= '0;
      won_q    <= 1'b0;
      mode_q   <= MODE_NORMAL;
      ext_q    <= 1'b0;
      ton_q    <= '0;
      tgap_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      mole_q   <= mole_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      flicks_q <= flicks_d;
      level_q  <= level_d;
      gtimer_q <= gtimer_d;
      won_q    <= won_d;
      mode_q   <= mode_d;
      ext_q    <= ext_d;
      ton_q    <= ton_d;
      tgap_q   <= tgap_d;
    end
  end

  // One-hot light drive for the lit mole
  always_comb begin
    lights = '0;
    for (int unsigned i = 0; i < NUM_MOLES; i++) begin
      lights[i] = (state_q == StLit) && (mole_q == IDX_W'(i));
    end
  end

  assign active_idx = (state_q == StLit) ? mole_q : '0;
  assign score      = score_q;
  assign misses     = misses_q;
  assign level      = level_q;
  assign playing    = in_play;
  assign game_over  = (state_q == StDone);
  assign won        = won_q;

endmodule
